// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave: arbiter side; master: requesters plus memory (as seen from the bench/top).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              a_req, b_req;
  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [2:0]        a_func3, b_func3;
  logic [31:0]       a_wdata, b_wdata;
  logic              b_lock;
  logic              a_gnt, b_gnt;
  logic              a_rvalid, b_rvalid;
  logic [31:0]       a_rdata, b_rdata;
  logic              a_err, b_err;
  logic              mem_store, mem_extract;
  logic [ADDR_W-1:0] mem_store_addr;
  logic [ADDR_W-1:0] mem_extract_addr;
  logic [2:0]        mem_func3;
  logic [31:0]       mem_store_value;
  logic [31:0]       mem_extract_value;

  modport slave (
    input  a_req, b_req, a_we, b_we,
    input  a_addr, b_addr, a_func3, b_func3,
    input  a_wdata, b_wdata, b_lock,
    output a_gnt, b_gnt, a_rvalid, b_rvalid,
    output a_rdata, b_rdata, a_err, b_err,
    output mem_store, mem_extract,
    output mem_store_addr, mem_extract_addr,
    output mem_func3, mem_store_value,
    input  mem_extract_value
  );

  modport master (
    output a_req, b_req, a_we, b_we,
    output a_addr, b_addr, a_func3, b_func3,
    output a_wdata, b_wdata, b_lock,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid,
    input  a_rdata, b_rdata, a_err, b_err,
    input  mem_store, mem_extract,
    input  mem_store_addr, mem_extract_addr,
    input  mem_func3, mem_store_value,
    output mem_extract_value
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: A (core) / B (loader) share one port, B may lock.
// Ports: clk, reset (async, active-low), bus (dmem_arbiter_if.slave).
// Macro DMEM_ARB_FIXED_PRIO_EN: A wins simultaneous requests in RR state.
module dmem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {ST_RR, ST_BLOCK} state_t;

  state_t      state, state_nx;
  logic        ptr_b, ptr_b_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic        a_gnt, b_gnt, any_gnt;
  logic        forced;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic [31:0]       sel_wdata;
  logic              bad;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       fmt;

  logic        a_rvalid_q, b_rvalid_q;
  logic        a_err_q, b_err_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  assign cnt_inc = cnt + CW'(1);
  // A's refusal in the grant cycle that took the lock counts as the first wait.
  assign forced = (state == ST_BLOCK) & bus.b_lock & bus.a_req &
                  (cnt_inc == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RR;
      ptr_b <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr_b <= ptr_b_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_b_nx = ptr_b;
    cnt_nx   = cnt;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    if (!reset) begin
      state_nx = state;
    end else if (state == ST_BLOCK && bus.b_lock) begin
      if (bus.a_req)
        cnt_nx = cnt_inc;
      if (forced) begin
        a_gnt    = 1'b1;
        cnt_nx   = '0;
        state_nx = ST_RR;
      end else begin
        b_gnt = bus.b_req;
      end
    end else begin
      cnt_nx   = '0;
      state_nx = ST_RR;
      if (bus.a_req && bus.b_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        a_gnt = 1'b1;
`else
        a_gnt = ~ptr_b;
        b_gnt = ptr_b;
`endif
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
      if (b_gnt && bus.b_lock)
        state_nx = ST_BLOCK;
    end
    if (a_gnt)
      ptr_b_nx = 1'b1;
    if (b_gnt)
      ptr_b_nx = 1'b0;
  end

  assign any_gnt   = a_gnt | b_gnt;
  assign sel_we    = b_gnt ? bus.b_we    : bus.a_we;
  assign sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
  assign sel_f3    = b_gnt ? bus.b_func3 : bus.a_func3;
  assign sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;

  always_comb begin
    bad = 1'b0;
    case (sel_f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = sel_addr[0];
      3'b010:         bad = |sel_addr[1:0];
      default:        bad = 1'b1;
    endcase
  end

  assign bus.mem_store        = any_gnt & sel_we & ~bad;
  assign bus.mem_extract      = any_gnt & ~sel_we & ~bad;
  assign bus.mem_store_addr   = any_gnt ? sel_addr : '0;
  assign bus.mem_extract_addr =
    any_gnt ? {2'b00, sel_addr[ADDR_W-1:2]} : '0;
  assign bus.mem_func3        = any_gnt ? sel_f3 : 3'b000;
  assign bus.mem_store_value  = any_gnt ? sel_wdata : 32'h0;

  assign byte_v = bus.mem_extract_value[{sel_addr[1:0], 3'b000} +: 8];
  assign half_v = sel_addr[1] ? bus.mem_extract_value[31:16]
                              : bus.mem_extract_value[15:0];

  always_comb begin
    fmt = 32'h0;
    case (sel_f3)
      3'b000:  fmt = {{24{byte_v[7]}}, byte_v};
      3'b100:  fmt = {24'h0, byte_v};
      3'b001:  fmt = {{16{half_v[15]}}, half_v};
      3'b101:  fmt = {16'h0, half_v};
      3'b010:  fmt = bus.mem_extract_value;
      default: fmt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= 32'h0;
      b_rdata_q  <= 32'h0;
    end else begin
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      a_err_q    <= a_gnt & bad;
      b_err_q    <= b_gnt & bad;
      a_rdata_q  <= (a_gnt & ~sel_we & ~bad) ? fmt : 32'h0;
      b_rdata_q  <= (b_gnt & ~sel_we & ~bad) ? fmt : 32'h0;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_err    = a_err_q;
  assign bus.b_err    = b_err_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane data memory model.
// The memory writes on the falling edge and reads combinationally.
module tb_dmem_arbiter;

  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [32];
  int          w_idx;
  int          w_ln;

  always @(negedge clk) begin
    if (bus.mem_store) begin
      w_idx = int'(bus.mem_store_addr[6:2]);
      w_ln  = int'(bus.mem_store_addr[1:0]);
      case (bus.mem_func3[1:0])
        2'b00:   mem[w_idx][w_ln*8 +: 8] = bus.mem_store_value[7:0];
        2'b01:   mem[w_idx][(w_ln/2)*16 +: 16] = bus.mem_store_value[15:0];
        default: mem[w_idx] = bus.mem_store_value;
      endcase
    end
  end

  assign bus.mem_extract_value = mem[bus.mem_extract_addr[4:0]];

  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0;
    bus.a_func3 = 3'b000; bus.a_wdata = 32'h0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0;
    bus.b_func3 = 3'b000; bus.b_wdata = 32'h0;
    bus.b_lock = 0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] ad,
                       input logic [2:0] f3, input logic [31:0] wd);
    bus.a_req = 1; bus.a_we = we; bus.a_addr = ad;
    bus.a_func3 = f3; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] ad,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic lk);
    bus.b_req = 1; bus.b_we = we; bus.b_addr = ad;
    bus.b_func3 = f3; bus.b_wdata = wd; bus.b_lock = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    set_a(0, 7'h04, 3'b010, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.mem_extract !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got gnt=%b ext=%b want 0 0",
               bus.a_gnt, bus.mem_extract);
    end
    tick();
    checks++;
    if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'h0 ||
        bus.a_err !== 1'b0 || bus.b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got rv=%b rd=%h err=%b want 0 0 0",
               bus.a_rvalid, bus.a_rdata, bus.a_err);
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    set_b(1, 7'h04, 3'b010, 32'hDEADBEEF, 0);
    tick();
    idle();
    set_a(0, 7'h04, 3'b010, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0 ||
        bus.mem_extract !== 1'b1 || bus.mem_extract_addr !== 7'd1) begin
      errors++;
      $display("FAIL lw_gnt got gnt=%b ext=%b eaddr=%0d want 1 1 1",
               bus.a_gnt, bus.mem_extract, bus.mem_extract_addr);
    end
    tick();
    idle();
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF ||
        bus.a_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_resp got rv=%b rd=%h err=%b want 1 deadbeef 0",
               bus.a_rvalid, bus.a_rdata, bus.a_err);
    end
    tick();
    checks++;
    if (bus.a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lw_one_cycle got rv=%b want 0", bus.a_rvalid);
    end
  endtask

  task automatic test_load_format();
    logic [6:0]  ad [4];
    logic [2:0]  f3 [4];
    logic [31:0] ex [4];
    ad = '{7'h07, 7'h07, 7'h06, 7'h06};
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    set_b(1, 7'h04, 3'b010, 32'h80FF0011, 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_a(0, ad[i], f3[i], 32'h0);
      tick();
      idle();
      checks++;
      if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== ex[i]) begin
        errors++;
        $display("FAIL fmt%0d got rv=%b rd=%h want 1 %h",
                 i, bus.a_rvalid, bus.a_rdata, ex[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    set_b(0, 7'h00, 3'b010, 32'h0, 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_a(0, 7'h04, 3'b010, 32'h0);
      set_b(0, 7'h08, 3'b010, 32'h0, 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (i % 2 == 0);
`endif
      @(negedge clk);
      checks++;
      if (bus.a_gnt !== exp_a || bus.b_gnt !== ~exp_a) begin
        errors++;
        $display("FAIL rr%0d got a=%b b=%b want a=%b b=%b",
                 i, bus.a_gnt, bus.b_gnt, exp_a, ~exp_a);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_lock();
    set_b(0, 7'h00, 3'b010, 32'h0, 1);
    @(negedge clk);
    checks++;
    if (bus.b_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lock_take got b=%b want 1", bus.b_gnt);
    end
    tick();
    set_a(0, 7'h04, 3'b010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold%0d got a=%b b=%b want a=0 b=1",
                 i, bus.a_gnt, bus.b_gnt);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_break got a=%b b=%b want a=1 b=0",
               bus.a_gnt, bus.b_gnt);
    end
    tick();
    bus.b_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lock_rr got a=%b want 1", bus.a_gnt);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_misaligned();
    set_a(1, 7'h02, 3'b010, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (bus.a_gnt !== 1'b1 || bus.mem_store !== 1'b0) begin
      errors++;
      $display("FAIL mis_sw got gnt=%b store=%b want 1 0",
               bus.a_gnt, bus.mem_store);
    end
    tick();
    set_a(0, 7'h04, 3'b011, 32'h0);
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b1 ||
        bus.a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mis_sw_resp got rv=%b err=%b rd=%h want 1 1 0",
               bus.a_rvalid, bus.a_err, bus.a_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_extract !== 1'b0) begin
      errors++;
      $display("FAIL bad_f3 got ext=%b want 0", bus.mem_extract);
    end
    tick();
    idle();
    checks++;
    if (bus.a_err !== 1'b1 || bus.a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_f3_resp got err=%b rd=%h want 1 0",
               bus.a_err, bus.a_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_b(1, 7'h08, 3'b010, 32'h12345678, 0);
    @(negedge clk);
    checks++;
    if (bus.mem_store !== 1'b1 || bus.mem_store_addr !== 7'h08 ||
        bus.mem_store_value !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_store got st=%b ad=%h v=%h want 1 08 12345678",
               bus.mem_store, bus.mem_store_addr, bus.mem_store_value);
    end
    tick();
    idle();
    set_a(0, 7'h08, 3'b010, 32'h0);
    checks++;
    if (bus.b_rvalid !== 1'b1 || bus.b_err !== 1'b0 ||
        bus.b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_sresp got rv=%b err=%b rd=%h want 1 0 0",
               bus.b_rvalid, bus.b_err, bus.b_rdata);
    end
    tick();
    idle();
    checks++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_load got rv=%b rd=%h want 1 12345678",
               bus.a_rvalid, bus.a_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_a(0, 7'h04, 3'b010, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    tick();
    idle();
    checks++;
    if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got rv=%b rd=%h want 0 0",
               bus.a_rvalid, bus.a_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (bus.a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got rv=%b want 0", bus.a_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_format();
    test_round_robin();
    test_lock();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
